cdb_rr_arbiter: RTL and testbench
=================================

# cdb_rr_arbiter

Round-robin arbiter that shares one valid/ready output channel, such as the common data bus feeding the pipeline skid buffers, between NREQ requesters, for example functional-unit writeback ports. It selects at most one requester per cycle, registers the winner's data and index into a single output stage, and guarantees starvation-free service. Latency is 1 cycle and throughput is 1 transfer/cycle under continuous downstream ready.

## Interface
- NREQ, 4: number of requesters; legal range 2..16.
- DWIDTH, 32: data width per requester.
- IDW, $clog2(NREQ): grant index width; derived, not overridden.

- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- i_data  input  NREQ*DWIDTH  requester data; requester k occupies bits [k*DWIDTH +: DWIDTH]
- i_valid  input  NREQ  per-requester valid
- o_ready  output  NREQ  per-requester ready; one-hot or zero
- o_data  output  DWIDTH  registered winner data
- o_valid  output  1  registered output valid
- o_grant_id  output  IDW  registered index of the requester whose data is in o_data
- i_ready  input  1  downstream ready

## Operation
- Output stage registers: data_rg, valid_rg, id_rg. Round-robin pointer ptr_rg is IDW bits wide and holds the highest-priority index.
- load = i_ready || ~valid_rg. The output stage can accept a new beat whenever load is 1.
- Winner selection: first k with i_valid[k]=1, scanning ptr_rg, ptr_rg+1, … mod NREQ. The scan wraps past NREQ-1 to 0 and stays within 0..NREQ-1 for non-power-of-2 NREQ.
- o_ready[k] = load && (k == winner) && |i_valid && ~reset. This is combinational from i_valid, i_ready and valid_rg.
- A transfer from requester k occurs when i_valid[k] && o_ready[k] are both 1.
- On load:
  - If any i_valid is 1: data_rg, id_rg and valid_rg load the winner's data, the winner's index and 1. ptr_rg loads (winner+1) mod NREQ.
  - If no i_valid is 1: valid_rg loads 0. data_rg, id_rg and ptr_rg hold.
- When load is 0 (o_valid && ~i_ready): all registers hold and all o_ready bits are 0. The output is stable while stalled.
- Fairness: a continuously valid requester is granted within NREQ load cycles.
- A requester may drop i_valid in any cycle without a handshake. Arbitration is re-evaluated every cycle and no grant is remembered across cycles.
- Reset values: o_valid=0, o_data=0, o_grant_id=0, ptr_rg=0, o_ready=all 0. Reset mid-operation discards any buffered beat.

## Timing
- Cycle N: handshake with requester k. Cycle N+1: o_valid=1, o_data=i_data[k], o_grant_id=k.
- Downstream transfer occurs on o_valid && i_ready. In that same cycle a new requester may be accepted, giving back-to-back beats with no bubble.
- Simultaneous downstream drain and upstream accept in one cycle: the new beat replaces the old one; nothing is lost or duplicated.
- Single requester continuously valid with i_ready=1: granted every cycle. ptr_rg moves to requester+1 each grant.
- In the cycle reset deasserts, o_ready stays 0. The first grant occurs in the following cycle at the earliest.

## Structure
- Shared package arb_pkg holds:
  - function rr_next(idx, n), returning (idx+1) mod n.
  - localparam MAX_NREQ = 16.
- One combinational sub-module, rr_priority_pick (parameters NREQ, IDW):
  - Inputs: req[NREQ], ptr[IDW].
  - Outputs: gnt_onehot[NREQ], gnt_idx[IDW], any.
  - Implemented as a double-width masked priority encoder.
- Top level holds the output registers, the pointer and the o_ready gating.

## Test plan
- Reset release, all i_valid=0, i_ready=1 for 10 cycles -> o_valid=0, o_ready=0000, o_data=0, o_grant_id=0 throughout.
- NREQ=4, i_valid=1111 held, i_ready=1 -> grants 0,1,2,3,0,… on consecutive cycles. o_grant_id follows one cycle later, with o_data equal to requester k's value (e.g. 32'hA000_000k).
- Only requester 2 valid with data 32'h1234_5678, i_ready=1 -> o_ready=0100 each cycle. Next cycle o_valid=1, o_data=32'h1234_5678, o_grant_id=2.
- i_valid=1111, i_ready held 0 for 5 cycles after the first beat is buffered -> o_ready=0000, and o_data/o_grant_id stay frozen. On i_ready=1, the next grant goes to the index after the buffered beat's index.
- NREQ=3, i_valid=101, ptr at 2 -> grant 2, then 0 (wrap past 2 to 0), then 2. ptr never holds 3.
- Assert reset for 1 cycle while o_valid=1 and requesters are active -> next cycle o_valid=0 and ptr_rg=0. The first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the common-data-bus round-robin arbiter.
//   MAX_NREQ : largest supported requester count
//   rr_next  : (idx + 1) mod n, used to advance the round-robin pointer
package arb_pkg;

  localparam int unsigned MAX_NREQ = 16;

  // Increment with wrap; avoids a modulo operator for non-power-of-2 n.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin priority pick.
//   req        : request vector
//   ptr        : highest-priority index (0..NREQ-1)
//   gnt_onehot : one-hot winner, zero when no request
//   gnt_idx    : winner index, zero when no request
//   any        : at least one request present
module rr_priority_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_mask;
  logic [2*NREQ-1:0] w_masked;

  // Window of NREQ bits starting at ptr over the doubled request vector;
  // the lowest set bit in that window is the round-robin winner.
  always_comb begin
    w_dbl  = {req, req};
    w_mask = '0;
    for (int unsigned j = 0; j < 2 * NREQ; j++) begin
      w_mask[j] = (j >= 32'(ptr)) && (j < 32'(ptr) + NREQ);
    end
    w_masked = w_dbl & w_mask;
  end

  // Lowest set bit of the masked vector, folded back into 0..NREQ-1.
  always_comb begin
    any     = 1'b0;
    gnt_idx = '0;
    for (int unsigned j = 0; j < 2 * NREQ; j++) begin
      if (w_masked[j] && !any) begin
        any     = 1'b1;
        gnt_idx = IDW'((j >= NREQ) ? (j - NREQ) : j);
      end
    end
    gnt_onehot = any ? (NREQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready output stage
// between NREQ requesters.
//   clk, reset  : clock, synchronous active-high reset
//   i_data      : requester k at [k*DWIDTH +: DWIDTH]
//   i_valid     : per-requester valid
//   o_ready     : per-requester ready (one-hot or zero, combinational)
//   o_data      : registered winner data
//   o_valid     : registered output valid
//   o_grant_id  : registered winner index
//   i_ready     : downstream ready
module cdb_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DWIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ*DWIDTH-1:0] i_data,
  input  logic [NREQ-1:0]        i_valid,
  output logic [NREQ-1:0]        o_ready,
  output logic [DWIDTH-1:0]      o_data,
  output logic                   o_valid,
  output logic [$clog2(NREQ)-1:0] o_grant_id,
  input  logic                   i_ready
);

  localparam int unsigned IDW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > MAX_NREQ) begin : g_bad_nreq
    $error("cdb_rr_arbiter: NREQ out of range");
  end

  logic [DWIDTH-1:0] r_data;
  logic              r_valid;
  logic [IDW-1:0]    r_id;
  logic [IDW-1:0]    r_ptr;

  logic              w_load;
  logic              w_any;
  logic [NREQ-1:0]   w_onehot;
  logic [IDW-1:0]    w_gnt_idx;

  rr_priority_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_pick (
    .req        (i_valid),
    .ptr        (r_ptr),
    .gnt_onehot (w_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  // Output stage can take a beat when empty or draining this cycle.
  assign w_load  = i_ready || !r_valid;
  assign o_ready = (w_load && w_any && !reset) ? w_onehot : '0;

  // Output stage and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_id    <= '0;
      r_ptr   <= '0;
    end else if (w_load) begin
      r_valid <= w_any;
      if (w_any) begin
        r_data <= i_data[32'(w_gnt_idx) * DWIDTH +: DWIDTH];
        r_id   <= w_gnt_idx;
        r_ptr  <= IDW'(rr_next(32'(w_gnt_idx), NREQ));
      end
    end
  end

  assign o_data     = r_data;
  assign o_valid    = r_valid;
  assign o_grant_id = r_id;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
// Directed, table-driven bench for cdb_rr_arbiter (NREQ=4) plus a
// hand-written wrap sequence on a NREQ=3 instance.
module tb_cdb_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NREQ=4 instance
  logic         rst4 = 1'b1;
  logic [127:0] d4 = '0;
  logic [3:0]   v4 = '0;
  logic [3:0]   ordy4;
  logic [31:0]  odata4;
  logic         ovld4;
  logic [1:0]   oid4;
  logic         rdy4 = 1'b1;

  cdb_rr_arbiter #(.NREQ(4), .DWIDTH(32)) u_dut4 (
    .clk        (clk),
    .reset      (rst4),
    .i_data     (d4),
    .i_valid    (v4),
    .o_ready    (ordy4),
    .o_data     (odata4),
    .o_valid    (ovld4),
    .o_grant_id (oid4),
    .i_ready    (rdy4)
  );

  // NREQ=3 instance
  logic         rst3 = 1'b1;
  logic [95:0]  d3 = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
  logic [2:0]   v3 = '0;
  logic [2:0]   ordy3;
  logic [31:0]  odata3;
  logic         ovld3;
  logic [1:0]   oid3;
  logic         rdy3 = 1'b1;

  cdb_rr_arbiter #(.NREQ(3), .DWIDTH(32)) u_dut3 (
    .clk        (clk),
    .reset      (rst3),
    .i_data     (d3),
    .i_valid    (v3),
    .o_ready    (ordy3),
    .o_data     (odata3),
    .o_valid    (ovld3),
    .o_grant_id (oid3),
    .i_ready    (rdy3)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic        rdy;
    logic [31:0] d2;
    logic [3:0]  e_rdy;
    logic        e_vld;
    logic [31:0] e_data;
    logic [1:0]  e_id;
  } vec_t;

  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  localparam logic [31:0] D2DEF = 32'hA000_0002;
  localparam logic [31:0] D2ALT = 32'h1234_5678;

  task automatic add(input logic rst, input logic [3:0] vld, input logic rdy,
                     input logic [31:0] d2, input logic [3:0] e_rdy,
                     input logic e_vld, input logic [31:0] e_data, input logic [1:0] e_id);
    vec_t v;
    v.rst = rst; v.vld = vld; v.rdy = rdy; v.d2 = d2;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data; v.e_id = e_id;
    vt.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial begin
    // reset held with requesters active
    add(1, 4'b1111, 1, D2DEF, 4'b0000, 0, 32'h0, 2'd0);
    // idle after reset release
    for (int i = 0; i < 10; i++) add(0, 4'b0000, 1, D2DEF, 4'b0000, 0, 32'h0, 2'd0);
    // all valid: rotate 0,1,2,3,0
    add(0, 4'b1111, 1, D2DEF, 4'b0001, 1, 32'hA000_0000, 2'd0);
    add(0, 4'b1111, 1, D2DEF, 4'b0010, 1, 32'hA000_0001, 2'd1);
    add(0, 4'b1111, 1, D2DEF, 4'b0100, 1, 32'hA000_0002, 2'd2);
    add(0, 4'b1111, 1, D2DEF, 4'b1000, 1, 32'hA000_0003, 2'd3);
    add(0, 4'b1111, 1, D2DEF, 4'b0001, 1, 32'hA000_0000, 2'd0);
    // only requester 2
    add(0, 4'b0100, 1, D2ALT, 4'b0100, 1, D2ALT, 2'd2);
    add(0, 4'b0100, 1, D2ALT, 4'b0100, 1, D2ALT, 2'd2);
    // ptr=3: buffer beat 3, then stall 5 cycles
    add(0, 4'b1111, 1, D2DEF, 4'b1000, 1, 32'hA000_0003, 2'd3);
    for (int i = 0; i < 5; i++) add(0, 4'b1111, 0, D2DEF, 4'b0000, 1, 32'hA000_0003, 2'd3);
    // release: next grant follows buffered index 3
    add(0, 4'b1111, 1, D2DEF, 4'b0001, 1, 32'hA000_0000, 2'd0);
    // no requests: valid drops, data/id hold
    add(0, 4'b0000, 1, D2DEF, 4'b0000, 0, 32'hA000_0000, 2'd0);
    add(0, 4'b0000, 0, D2DEF, 4'b0000, 0, 32'hA000_0000, 2'd0);
    // empty stage accepts even with i_ready=0 (ptr=1, only 0 valid)
    add(0, 4'b0001, 0, D2DEF, 4'b0001, 1, 32'hA000_0000, 2'd0);
    add(0, 4'b0110, 0, D2DEF, 4'b0000, 1, 32'hA000_0000, 2'd0);
    // reset mid-operation, then lowest valid index wins (ptr back to 0)
    add(1, 4'b1111, 1, D2DEF, 4'b0000, 0, 32'h0, 2'd0);
    add(0, 4'b1001, 1, D2DEF, 4'b0001, 1, 32'hA000_0000, 2'd0);
    add(0, 4'b1001, 1, D2DEF, 4'b1000, 1, 32'hA000_0003, 2'd3);

    #1;
    for (int i = 0; i < vt.size(); i++) begin
      rst4 = vt[i].rst;
      v4   = vt[i].vld;
      rdy4 = vt[i].rdy;
      d4   = {32'hA000_0003, vt[i].d2, 32'hA000_0001, 32'hA000_0000};
      #1;
      check($sformatf("v%0d o_ready", i), 32'(ordy4), 32'(vt[i].e_rdy));
      @(posedge clk); #1;
      check($sformatf("v%0d o_valid", i), 32'(ovld4), 32'(vt[i].e_vld));
      check($sformatf("v%0d o_data", i), odata4, vt[i].e_data);
      check($sformatf("v%0d o_grant_id", i), 32'(oid4), 32'(vt[i].e_id));
    end
    v4 = '0;

    // NREQ=3 wrap: put ptr at 2 via a grant to 1, then i_valid=101
    @(posedge clk); #1;
    rst3 = 1'b0;
    v3 = 3'b010;
    #1; check("n3 g1 o_ready", 32'(ordy3), 32'h2);
    @(posedge clk); #1;
    check("n3 g1 id", 32'(oid3), 32'd1);
    v3 = 3'b101;
    #1; check("n3 g2 o_ready", 32'(ordy3), 32'h4);
    @(posedge clk); #1;
    check("n3 g2 id", 32'(oid3), 32'd2);
    check("n3 g2 data", odata3, 32'hA000_0002);
    #1; check("n3 wrap o_ready", 32'(ordy3), 32'h1);
    @(posedge clk); #1;
    check("n3 wrap id", 32'(oid3), 32'd0);
    check("n3 wrap data", odata3, 32'hA000_0000);
    #1; check("n3 g4 o_ready", 32'(ordy3), 32'h4);
    @(posedge clk); #1;
    check("n3 g4 id", 32'(oid3), 32'd2);
    check("n3 g4 valid", 32'(ovld3), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
